rom_sweep_reader: RTL and testbench

Parametrised successor of the single-step rom_reader front end. Drives a parallel ROM's address bus and chip-select, waits a programmable access time, then samples the data bus. Each word is presented on a valid/ready output handshake to the downstream dump/UART logic. Supports manual stepping (increment/decrement) and an automatic sweep over a configurable address window, so whole chips (3601/556PT4 and wider parts) are read without host intervention.

---
 rtl/rom_sweep_reader.sv | 185 ++++++++++++++++++
 tb/tb_rom_sweep_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_sweep_reader.sv
// Parallel ROM reader: manual step or automatic window sweep, valid/ready word output.
// Optional ROM_CHECKSUM_EN adds a 16-bit running sum of words accepted during an auto sweep.
module rom_sweep_reader #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 11,
    parameter int unsigned ACCESS_CYCLES = 4,
    parameter int unsigned START_ADDRESS = 0,
    parameter int unsigned END_ADDRESS   = 2**ADDRESS_WIDTH - 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     auto_mode,
    input  logic                     increment_address,
    input  logic                     decrement_address,
    input  logic                     abort,
    input  logic [DATA_WIDTH-1:0]    rom_data_in,
    output logic [ADDRESS_WIDTH-1:0] rom_address,
    output logic                     rom_cs_n,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_valid,
    input  logic                     data_ready,
`ifdef ROM_CHECKSUM_EN
    output logic [15:0]              checksum,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [3:0]               operation
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ST_W  = 3;

    localparam logic [ST_W-1:0] S_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] S_SETUP  = 3'd1;
    localparam logic [ST_W-1:0] S_WAIT   = 3'd2;
    localparam logic [ST_W-1:0] S_SAMPLE = 3'd3;
    localparam logic [ST_W-1:0] S_HOLD   = 3'd4;
    localparam logic [ST_W-1:0] S_NEXT   = 3'd5;

    localparam logic [ADDRESS_WIDTH-1:0] START_A = ADDRESS_WIDTH'(START_ADDRESS);
    localparam logic [ADDRESS_WIDTH-1:0] END_A   = ADDRESS_WIDTH'(END_ADDRESS);
    localparam logic [CNT_W-1:0]         ACC_C   = CNT_W'(ACCESS_CYCLES);

    logic [ST_W-1:0]          state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     cs_n_q, cs_n_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     auto_q, auto_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
`ifdef ROM_CHECKSUM_EN
    logic [15:0]              sum_q, sum_d;
`endif

    // Next-state and registered-output logic; abort overrides every state.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        auto_d  = auto_q;
        cnt_d   = cnt_q;
`ifdef ROM_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        if (abort) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        auto_d  = auto_mode;
                        state_d = S_SETUP;
                        if (auto_mode) begin
                            addr_d = START_A;
`ifdef ROM_CHECKSUM_EN
                            sum_d  = 16'd0;
`endif
                        end
                    end else if (!auto_mode && (increment_address != decrement_address)) begin
                        auto_d  = 1'b0;
                        state_d = S_SETUP;
                        if (increment_address) begin
                            addr_d = (addr_q == END_A) ? START_A : addr_q + ADDRESS_WIDTH'(1);
                        end else begin
                            addr_d = (addr_q == START_A) ? END_A : addr_q - ADDRESS_WIDTH'(1);
                        end
                    end
                end
                S_SETUP: begin
                    cnt_d   = ACC_C;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    data_d  = rom_data_in;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (data_ready) begin
                        valid_d = 1'b0;
                        state_d = S_NEXT;
`ifdef ROM_CHECKSUM_EN
                        if (auto_q) begin
                            sum_d = sum_q + 16'(data_q);
                        end
`endif
                    end
                end
                S_NEXT: begin
                    if (!auto_q) begin
                        state_d = S_IDLE;
                    end else if (addr_q == END_A) begin
                        addr_d  = START_A;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = addr_q + ADDRESS_WIDTH'(1);
                        state_d = S_SETUP;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
        // Chip select is active while the address is presented and the ROM is being sampled.
        cs_n_d = !((state_d == S_SETUP) || (state_d == S_WAIT) || (state_d == S_SAMPLE));
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= START_A;
            cs_n_q  <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            auto_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef ROM_CHECKSUM_EN
            sum_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cs_n_q  <= cs_n_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            auto_q  <= auto_d;
            cnt_q   <= cnt_d;
`ifdef ROM_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign rom_address = addr_q;
    assign rom_cs_n    = cs_n_q;
    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign operation   = {1'b0, state_q};
`ifdef ROM_CHECKSUM_EN
    assign checksum    = sum_q;
`endif

endmodule

// File: tb/tb_rom_sweep_reader.sv
// Self-checking bench for rom_sweep_reader: manual stepping, sweeps, backpressure, abort, reset.
module tb_rom_sweep_reader;

    localparam int unsigned DW = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned AC = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          auto_mode = 1'b0;
    logic          increment_address = 1'b0;
    logic          decrement_address = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] rom_data_in;
    logic [AW-1:0] rom_address;
    logic          rom_cs_n;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ready = 1'b0;
    logic          busy;
    logic          done;
    logic [3:0]    operation;
`ifdef ROM_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int model_addr = 0;

    rom_sweep_reader #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ACCESS_CYCLES(AC),
        .START_ADDRESS(0), .END_ADDRESS(255)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .auto_mode(auto_mode),
        .increment_address(increment_address), .decrement_address(decrement_address),
        .abort(abort), .rom_data_in(rom_data_in), .rom_address(rom_address),
        .rom_cs_n(rom_cs_n), .data_out(data_out), .data_valid(data_valid),
        .data_ready(data_ready),
`ifdef ROM_CHECKSUM_EN
        .checksum(checksum),
`endif
        .busy(busy), .done(done), .operation(operation)
    );

    always #5 clk = ~clk;

    // ROM contents: low address nibble xor 0xA.
    assign rom_data_in = rom_address[3:0] ^ 4'hA;

    function automatic logic [3:0] rom_word(input int a);
        return 4'((a % 16) ^ 10);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_checks++; if (rom_address !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", rom_address); end
        n_checks++; if (rom_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %0b expected 1", rom_cs_n); end
        n_checks++; if ({data_valid, busy, done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %0b expected 000", {data_valid, busy, done}); end
        n_checks++; if (data_out !== 4'h0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", data_out); end
        n_checks++; if (operation !== 4'd0) begin n_fail++; $display("FAIL reset_op: got %0d expected 0", operation); end
        reset_n = 1'b1;
        model_addr = 0;
        tick();
    endtask

    // kind: 0 = manual start, 1 = increment, 2 = decrement
    task automatic test_manual_read(input int kind);
        int exp_a;
        int n;
        exp_a = model_addr;
        if (kind == 1) exp_a = (model_addr + 1) % 256;
        if (kind == 2) exp_a = (model_addr + 255) % 256;
        auto_mode = 1'b0;
        data_ready = 1'b1;
        start = (kind == 0);
        increment_address = (kind == 1);
        decrement_address = (kind == 2);
        tick();
        start = 1'b0; increment_address = 1'b0; decrement_address = 1'b0;
        n = 0;
        do begin tick(); n++; end while (data_valid !== 1'b1 && n < 40);
        n_checks++; if (n != AC + 2) begin n_fail++; $display("FAIL manual_latency: got %0d expected %0d", n, AC + 2); end
        n_checks++; if (rom_address !== 8'(exp_a)) begin n_fail++; $display("FAIL manual_addr: got %0h expected %0h", rom_address, exp_a); end
        n_checks++; if (data_out !== rom_word(exp_a)) begin n_fail++; $display("FAIL manual_data: got %0h expected %0h", data_out, rom_word(exp_a)); end
        tick();
        n_checks++; if ({data_valid, operation} !== {1'b0, 4'd5}) begin n_fail++; $display("FAIL manual_accept: got %0h expected 05", {data_valid, operation}); end
        tick();
        n_checks++; if ({busy, operation} !== 5'd0) begin n_fail++; $display("FAIL manual_idle: got %0h expected 0", {busy, operation}); end
        model_addr = exp_a;
    endtask

    task automatic test_manual();
        for (int i = 0; i < 3; i++) test_manual_read(1);
    endtask

    task automatic test_manual_wrap();
        for (int i = 0; i < 3; i++) test_manual_read(2);
        test_manual_read(2);
        test_manual_read(1);
    endtask

    // Random commands, including combinations that must be ignored.
    task automatic test_random_manual();
        for (int i = 0; i < 24; i++) begin
            int r;
            r = $urandom_range(0, 4);
            if (r <= 2) begin
                test_manual_read(r);
            end else begin
                auto_mode = (r == 4);
                increment_address = 1'b1;
                decrement_address = (r == 3);
                tick();
                increment_address = 1'b0; decrement_address = 1'b0; auto_mode = 1'b0;
                tick();
                n_checks++; if ({busy, rom_address} !== {1'b0, 8'(model_addr)}) begin n_fail++; $display("FAIL noop_cmd: got %0h expected %0h", {busy, rom_address}, model_addr); end
            end
        end
    endtask

    task automatic test_sweep(input bit random_ready);
        int words, done_cnt, order_err, interval_err, stall_err, cyc, last_acc, exp_a;
        bit stall_done;
        logic [3:0] d0;
        logic [7:0] a0;
        words = 0; done_cnt = 0; order_err = 0; interval_err = 0; stall_err = 0;
        cyc = 0; last_acc = -1; exp_a = 0; stall_done = 1'b0;
        auto_mode = 1'b1; start = 1'b1; data_ready = 1'b1;
        tick();
        start = 1'b0; auto_mode = 1'b0;
        while (cyc < 4000) begin
            if (done === 1'b1) begin
                done_cnt++;
                if (words != 256) order_err++;
            end
            if (busy !== 1'b1) break;
            if (random_ready) begin
                if (data_valid === 1'b1 && !stall_done && words == 100) begin
                    d0 = data_out; a0 = rom_address;
                    for (int k = 0; k < 20; k++) begin
                        data_ready = 1'b0;
                        start = k[0];
                        increment_address = ~k[0];
                        tick();
                        if (data_out !== d0 || rom_address !== a0 || data_valid !== 1'b1 || operation !== 4'd4) stall_err++;
                    end
                    start = 1'b0; increment_address = 1'b0;
                    stall_done = 1'b1;
                    cyc += 20;
                end
                data_ready = ($urandom_range(0, 2) != 0);
            end
            if (data_valid === 1'b1 && data_ready) begin
                if (data_out !== rom_word(exp_a) || rom_address !== 8'(exp_a)) order_err++;
                if (last_acc >= 0 && (cyc - last_acc) != AC + 4) interval_err++;
                last_acc = cyc;
                words++;
                exp_a++;
            end
            tick();
            cyc++;
        end
        data_ready = 1'b1;
        n_checks++; if (words != 256) begin n_fail++; $display("FAIL sweep_words: got %0d expected 256", words); end
        n_checks++; if (order_err != 0) begin n_fail++; $display("FAIL sweep_order: got %0d errors expected 0", order_err); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL sweep_done_count: got %0d expected 1", done_cnt); end
        n_checks++; if (rom_address !== 8'h00) begin n_fail++; $display("FAIL sweep_end_addr: got %0h expected 0", rom_address); end
        if (!random_ready) begin
            n_checks++; if (interval_err != 0) begin n_fail++; $display("FAIL sweep_throughput: got %0d bad intervals expected 0", interval_err); end
        end else begin
            n_checks++; if (stall_err != 0 || !stall_done) begin n_fail++; $display("FAIL backpressure_hold: got %0d errors (stalled=%0b) expected 0", stall_err, stall_done); end
        end
`ifdef ROM_CHECKSUM_EN
        n_checks++; if (checksum !== 16'h0780) begin n_fail++; $display("FAIL sweep_checksum: got %0h expected 0780", checksum); end
`endif
        tick();
        n_checks++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL sweep_done_width: got %0b expected 00", {done, busy}); end
        model_addr = 0;
    endtask

    task automatic sweep_until(input int addr, output bit hit);
        int n;
        n = 0;
        auto_mode = 1'b1; start = 1'b1; data_ready = 1'b1;
        tick();
        start = 1'b0; auto_mode = 1'b0;
        while (!(rom_address === 8'(addr) && operation === 4'd2) && n < 4000) begin
            tick();
            n++;
        end
        hit = (n < 4000);
    endtask

    task automatic test_abort();
        bit hit;
        sweep_until(8'h40, hit);
        n_checks++; if (!hit) begin n_fail++; $display("FAIL abort_reach: got timeout expected address 40 in WAIT"); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if ({busy, operation} !== 5'd0) begin n_fail++; $display("FAIL abort_idle: got %0h expected 0", {busy, operation}); end
        n_checks++; if ({rom_cs_n, data_valid, done} !== 3'b100) begin n_fail++; $display("FAIL abort_outputs: got %0b expected 100", {rom_cs_n, data_valid, done}); end
        n_checks++; if (rom_address !== 8'h40) begin n_fail++; $display("FAIL abort_addr: got %0h expected 40", rom_address); end
        tick();
        n_checks++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL abort_no_done: got %0b expected 00", {done, busy}); end
        model_addr = 8'h40;
    endtask

    task automatic test_reset_mid_wait();
        bit hit;
        sweep_until(8'h37, hit);
        n_checks++; if (!hit) begin n_fail++; $display("FAIL rst_reach: got timeout expected address 37 in WAIT"); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if ({operation, rom_address} !== 12'h000) begin n_fail++; $display("FAIL rst_async_state: got %0h expected 000", {operation, rom_address}); end
        n_checks++; if ({rom_cs_n, data_valid, busy, done} !== 4'b1000) begin n_fail++; $display("FAIL rst_async_flags: got %0b expected 1000", {rom_cs_n, data_valid, busy, done}); end
        n_checks++; if (data_out !== 4'h0) begin n_fail++; $display("FAIL rst_async_data: got %0h expected 0", data_out); end
        tick();
        reset_n = 1'b1;
        model_addr = 0;
        tick();
        test_manual_read(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_manual();
        test_manual_wrap();
        test_random_manual();
        test_sweep(1'b0);
        test_sweep(1'b1);
        test_abort();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
